// File: rtl/lvda_int_pkg.sv
// Shared constants and types for the LVDA interrupt priority scheduler.
// Interrupt IDs are index+1 so that zero can mean "no interrupt".
package lvda_int_pkg;

   localparam int NUM_INT = 13;
   localparam int ID_W    = 4;

   localparam logic [ID_W-1:0] ID_NONE = '0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } sched_state_e;

   // One-hot mask for an interrupt ID; ID_NONE or an out-of-range ID gives zero.
   function automatic logic [NUM_INT-1:0] id_to_mask(input logic [ID_W-1:0] id);
      logic [NUM_INT-1:0] one;
      logic [NUM_INT-1:0] mask;
      one  = {{(NUM_INT-1){1'b0}}, 1'b1};
      mask = '0;
      if ((id != ID_NONE) && (id <= ID_W'(NUM_INT))) begin
         mask = one << (id - ID_W'(1));
      end
      return mask;
   endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder; returns index+1 of the winning request.
// Output is ID_NONE with valid low when nothing is requesting.
module int_prio_enc
   import lvda_int_pkg::*;
(
   input  logic [NUM_INT-1:0] req,
   output logic               valid,
   output logic [ID_W-1:0]    id
);

   always_comb begin
      valid = |req;
      id    = ID_NONE;
      for (int i = NUM_INT - 1; i >= 0; i--) begin
         if (req[i]) begin
            id = ID_W'(i + 1);
         end
      end
   end

endmodule

// File: rtl/int_priority_sched.sv
// Interrupt priority scheduler: latches source edges into a pending register,
// masks with the ICR inhibit bits and runs the request/ack/done handshake.
module int_priority_sched
   import lvda_int_pkg::*;
(
   input  logic               SIM_CLK,
   input  logic               SIM_RST,
   input  logic [NUM_INT-1:0] INT_SRC,
   input  logic [NUM_INT-1:0] ICR_N,
   input  logic               INT_ACK,
   input  logic               INT_DONE,
   input  logic [NUM_INT-1:0] CLR_PEND,
   output logic               INT_REQ,
   output logic [ID_W-1:0]    INT_ID,
   output logic [NUM_INT-1:0] INT_REG,
   output logic               BUSY
);

   // Handshake: INT_REQ rises with INT_ID valid; the computer answers with a
   // one-cycle INT_ACK while INT_REQ is high, then a one-cycle INT_DONE once
   // servicing ends. Pulses arriving in any other state are ignored.

   sched_state_e       state_q, state_d;
   logic [NUM_INT-1:0] src_q, src_d;
   logic [NUM_INT-1:0] pend_q, pend_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic               req_q, req_d;
   logic               busy_q, busy_d;

   logic [NUM_INT-1:0] edge_w;
   logic [NUM_INT-1:0] eligible;
   logic [NUM_INT-1:0] cur_mask;
   logic [NUM_INT-1:0] ack_clr;
   logic               ack_fire;
   logic               cur_live;
   logic               win_valid;
   logic [ID_W-1:0]    win_id;

   int_prio_enc u_enc (
      .req   (eligible),
      .valid (win_valid),
      .id    (win_id)
   );

   always_comb begin
      edge_w   = INT_SRC & ~src_q;
      eligible = pend_q & ICR_N;
      cur_mask = id_to_mask(id_q);
      cur_live = |(cur_mask & eligible);
      ack_fire = (state_q == ST_REQ) && INT_ACK;
      ack_clr  = ack_fire ? cur_mask : '0;
   end

   // A new edge wins over both PIO clear and acknowledge clear.
   always_comb begin
      src_d  = INT_SRC;
      pend_d = (pend_q & ~(CLR_PEND | ack_clr)) | edge_w;
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      req_d   = req_q;
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               id_d    = win_id;
               req_d   = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (ack_fire) begin
               req_d   = 1'b0;
               state_d = ST_SERVICE;
            end else if (!cur_live) begin
               req_d   = 1'b0;
               id_d    = ID_NONE;
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (INT_DONE) begin
               id_d    = ID_NONE;
               state_d = ST_IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            id_d    = ID_NONE;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // src_q resets high so lines already asserted at reset release do not fire.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         state_q <= ST_IDLE;
         src_q   <= '1;
         pend_q  <= '0;
         id_q    <= ID_NONE;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         pend_q  <= pend_d;
         id_q    <= id_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
      end
   end

   assign INT_REQ = req_q;
   assign INT_ID  = id_q;
   assign INT_REG = pend_q;
   assign BUSY    = busy_q;

endmodule
